scaler_v_sched: RTL and testbench
=================================

Name: scaler_v_sched

Overview:
- Frame/line scheduler and configuration controller for the vertical linear scaler.
- Shadows the software scale configuration and applies it only at frame start.
- At every input line, decides whether that line produces an output line and supplies the interpolation phase (dy).
- Checks input line geometry and reports per-frame line counts.
- Sits between the video input timing and the scaler_v datapath; replaces the datapath's internal line-decision logic.

Parameters:
- LINE_STEP, 4096: fixed-point 1.000 for scale_step; power of two.
- LINE_IN_SIZE_MAX, 1024: max pixels per input line; also the line-buffer depth.
- ACC_WIDTH, 32: width of the input and output line accumulators.
- DY_WIDTH, $clog2(LINE_STEP)-1: phase width; matches the linear table address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cfg_scale_step  in  16  unsigned fixed point; LINE_STEP = 1.000
- cfg_line_in_size  in  16  expected pixels per input line
- cfg_wr  in  1  one-cycle strobe; captures cfg_* into pending registers
- vs_i  in  1  frame valid (high = active frame)
- hs_i  in  1  horizontal blank (high = blank)
- de_i  in  1  pixel valid
- scale_step_o  out  16  active scale step
- line_in_size_o  out  16  active line size
- line_en_o  out  1  current input line produces an output line
- dy_o  out  DY_WIDTH  interpolation phase for the current line
- frame_done_o  out  1  one-cycle pulse at frame end
- frame_lines_in_o  out  16  input lines in the last frame
- frame_lines_out_o  out  16  output lines in the last frame
- err_len_o  out  1  sticky: some line length differed from line_in_size_o
- err_ovf_o  out  1  sticky: some line exceeded LINE_IN_SIZE_MAX pixels
- err_cfg_o  out  1  sticky: scale_step of 0 was applied
- err_clr  in  1  clears all sticky errors

Behaviour:
- **Reset values:**
  - scale_step_o = LINE_STEP; line_in_size_o = LINE_IN_SIZE_MAX.
  - All other outputs 0; pending flag 0; accumulators 0.
  - FSM in S_WAIT_LOW.
- **Edge detection:** vs_i and hs_i are registered once. Edges are computed from the current versus the registered value, so all decisions are 1 cycle after the input edge.
- **FSM:**
  - S_WAIT_LOW: go to S_IDLE when vs_i = 0. After reset, any partially seen frame is ignored.
  - S_IDLE: on vs rising edge, apply config and clear accumulators and counters, then go to S_HBLANK.
  - S_HBLANK: on hs falling edge, do the line decision, then go to S_LINE. On vs falling edge, go to S_FRAME_END.
  - S_LINE: count de_i. On hs rising edge, do the length check, then go to S_HBLANK. On vs falling edge, do the length check, then go to S_FRAME_END.
  - S_FRAME_END: one cycle. Pulse frame_done_o, latch the frame_lines_* outputs, then go to S_IDLE.
- **Config apply:**
  - cfg_wr sets the pending registers and the pending flag.
  - At frame start, if pending is set: copy pending to active and clear the flag.
  - If the applied scale_step is 0: use LINE_STEP instead and set err_cfg_o.
  - cfg_wr in the same cycle as frame start: active takes the older pending value; the new write stays pending for the next frame.
- **Line decision** (at hs falling edge; outputs valid from the next cycle and held for the whole line and its following blank):
  - acc_in_next = acc_in + LINE_STEP.
  - line_en_o = (acc_in_next > acc_out).
  - dy_o = acc_out[1 +: DY_WIDTH].
  - If line_en_o: acc_out += scale_step_o and lines_out increments.
  - acc_in = acc_in_next; lines_in increments.
  - At most one output line per input line; upscaling beyond 1:1 is unsupported and saturates at 1:1.
- **Length check:**
  - px_cnt counts de_i in S_LINE and saturates at LINE_IN_SIZE_MAX+1.
  - At line end: px_cnt ≠ line_in_size_o sets err_len_o; px_cnt > LINE_IN_SIZE_MAX sets err_ovf_o.
  - de_i outside S_LINE is ignored.
- **Counters:** lines_in and lines_out saturate at 16'hFFFF; the accumulators wrap modulo 2^ACC_WIDTH.
- **Errors:** err_clr and an error-set event in the same cycle leave the error set.
- **Reset mid-frame:** state is lost; no frame_done_o for that frame; the block resumes after vs_i is seen low.

Decomposition:
- Shared package scaler_pkg holds:
  - the FSM state enum;
  - LINE_STEP default;
  - DY_WIDTH derivation function;
  - the error flag index constants, shared with scaler_v.
- One natural sub-module, scaler_cfg_shadow: holds the pending/active registers, the pending flag and the zero-step substitution.

Test Plan:
- **1:1 scale:** cfg_scale_step=4096, 8 lines of 16 px, line_in_size=16 → line_en_o=1 on all lines; dy_o=0; frame_lines_in_o=8, frame_lines_out_o=8; no errors.
- **2:1 downscale:** scale_step=8192, 8 lines → line_en_o pattern 1,0,1,0,…; frame_lines_out_o=4.
- **Mid-frame cfg_wr:** cfg_wr of 6144 during line 3 → scale_step_o unchanged until the next vs rising edge, then 6144. Then cfg_wr in the same cycle as vs rising → the old pending value is applied and the new one is applied a frame later.
- **Length errors:** one line of 15 px with size 16 → err_len_o=1. Then a line of 1100 px → err_ovf_o=1. err_clr clears both.
- **Reset during line 4:** rst high for 1 cycle → outputs return to reset values; no frame_done_o for that frame; the next full frame reports correct counts.
- **Zero step:** cfg_scale_step=0 applied → scale_step_o=4096 and err_cfg_o=1.

Source files
------------

// File: rtl/scaler_pkg.sv
// Shared types and constants for the vertical scaler (scheduler and datapath).
// Latency: n/a (package only).
// Backpressure: n/a.
package scaler_pkg;

  // Fixed-point 1.000 for the scale step; must be a power of two.
  localparam int unsigned LINE_STEP_DEF = 4096;

  // Sticky error flag positions, shared with the scaler_v datapath.
  localparam int unsigned ERR_LEN_IDX = 0;
  localparam int unsigned ERR_OVF_IDX = 1;
  localparam int unsigned ERR_CFG_IDX = 2;
  localparam int unsigned ERR_NUM     = 3;

  typedef enum logic [2:0] {
    S_WAIT_LOW  = 3'd0,
    S_IDLE      = 3'd1,
    S_HBLANK    = 3'd2,
    S_LINE      = 3'd3,
    S_FRAME_END = 3'd4
  } sched_state_e;

  // Phase width matches the linear interpolation table address.
  function automatic int unsigned dy_width_f(input int unsigned line_step);
    return $clog2(line_step) - 1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/scaler_cfg_shadow.sv
// Pending/active shadow of the scale configuration, applied only on apply_i.
// Latency: active registers update 1 cycle after apply_i; zero_step_o is same-cycle.
// Backpressure: none; cfg_wr is always accepted (last write before apply wins).
// Ports: cfg_* / cfg_wr software side; apply_i frame-start strobe;
//        scale_step_o / line_in_size_o active values; zero_step_o pulse when a 0 step is applied.
module scaler_cfg_shadow
  import scaler_pkg::*;
#(
  parameter logic [15:0] LINE_STEP     = 16'(LINE_STEP_DEF),
  parameter logic [15:0] LINE_SIZE_RST = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_scale_step,
  input  logic [15:0] cfg_line_in_size,
  input  logic        cfg_wr,
  input  logic        apply_i,
  output logic [15:0] scale_step_o,
  output logic [15:0] line_in_size_o,
  output logic        zero_step_o
);

  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_step_q, pend_step_d;
  logic [15:0] pend_size_q, pend_size_d;
  logic [15:0] act_step_q, act_step_d;
  logic [15:0] act_size_q, act_size_d;
  logic        take;

  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_step_d = pend_step_q;
    pend_size_d = pend_size_q;
    act_step_d  = act_step_q;
    act_size_d  = act_size_q;
    take        = apply_i & pend_vld_q;

    if (take) begin
      // A zero step would stall the output accumulator; fall back to 1:1.
      act_step_d = (pend_step_q == 16'd0) ? LINE_STEP : pend_step_q;
      act_size_d = pend_size_q;
      pend_vld_d = 1'b0;
    end
    // Evaluated after the apply so a write in the apply cycle stays pending.
    if (cfg_wr) begin
      pend_step_d = cfg_scale_step;
      pend_size_d = cfg_line_in_size;
      pend_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q  <= 1'b0;
      pend_step_q <= LINE_STEP;
      pend_size_q <= LINE_SIZE_RST;
      act_step_q  <= LINE_STEP;
      act_size_q  <= LINE_SIZE_RST;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_step_q <= pend_step_d;
      pend_size_q <= pend_size_d;
      act_step_q  <= act_step_d;
      act_size_q  <= act_size_d;
    end
  end

  assign scale_step_o   = act_step_q;
  assign line_in_size_o = act_size_q;
  assign zero_step_o    = take & (pend_step_q == 16'd0);

endmodule

// File: rtl/scaler_v_sched.sv
// Frame/line scheduler for the vertical scaler: per-line output decision and phase.
// Latency: decisions 1 cycle after the input edge; outputs valid the cycle after that.
// Backpressure: none; follows video timing, no stall capability.
// Ports: vs_i/hs_i/de_i video timing; cfg_* software config; line_en_o/dy_o per-line
//        schedule; frame_* per-frame report; err_* sticky errors cleared by err_clr.
module scaler_v_sched
  import scaler_pkg::*;
#(
  parameter int unsigned LINE_STEP        = LINE_STEP_DEF,
  parameter int unsigned LINE_IN_SIZE_MAX = 1024,
  parameter int unsigned ACC_WIDTH        = 32,
  parameter int unsigned DY_WIDTH         = dy_width_f(LINE_STEP)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         cfg_scale_step,
  input  logic [15:0]         cfg_line_in_size,
  input  logic                cfg_wr,
  input  logic                vs_i,
  input  logic                hs_i,
  input  logic                de_i,
  output logic [15:0]         scale_step_o,
  output logic [15:0]         line_in_size_o,
  output logic                line_en_o,
  output logic [DY_WIDTH-1:0] dy_o,
  output logic                frame_done_o,
  output logic [15:0]         frame_lines_in_o,
  output logic [15:0]         frame_lines_out_o,
  output logic                err_len_o,
  output logic                err_ovf_o,
  output logic                err_cfg_o,
  input  logic                err_clr
);

  localparam logic [ACC_WIDTH-1:0] STEP_ACC = ACC_WIDTH'(LINE_STEP);
  localparam logic [15:0]          PX_MAX   = 16'(LINE_IN_SIZE_MAX);
  localparam logic [15:0]          PX_SAT   = 16'(LINE_IN_SIZE_MAX + 1);

  sched_state_e          state_q, state_d;
  logic                  vs_q, hs_q;
  logic                  vs_rise, vs_fall, hs_rise, hs_fall;
  logic [ACC_WIDTH-1:0]  acc_in_q, acc_in_d, acc_out_q, acc_out_d, acc_in_nxt;
  logic [15:0]           lines_in_q, lines_in_d, lines_out_q, lines_out_d;
  logic [15:0]           px_cnt_q, px_cnt_d;
  logic                  line_en_q, line_en_d;
  logic [DY_WIDTH-1:0]   dy_q, dy_d;
  logic [15:0]           frame_lines_in_q, frame_lines_in_d;
  logic [15:0]           frame_lines_out_q, frame_lines_out_d;
  logic [ERR_NUM-1:0]    err_q, err_d, err_set;
  logic                  cfg_apply, cfg_zero_step, line_end, to_frame_end;

  scaler_cfg_shadow #(
    .LINE_STEP     (16'(LINE_STEP)),
    .LINE_SIZE_RST (16'(LINE_IN_SIZE_MAX))
  ) u_cfg_shadow (
    .clk              (clk),
    .rst              (rst),
    .cfg_scale_step   (cfg_scale_step),
    .cfg_line_in_size (cfg_line_in_size),
    .cfg_wr           (cfg_wr),
    .apply_i          (cfg_apply),
    .scale_step_o     (scale_step_o),
    .line_in_size_o   (line_in_size_o),
    .zero_step_o      (cfg_zero_step)
  );

  assign vs_rise = vs_i & ~vs_q;
  assign vs_fall = ~vs_i & vs_q;
  assign hs_rise = hs_i & ~hs_q;
  assign hs_fall = ~hs_i & hs_q;

  always_comb begin
    state_d           = state_q;
    acc_in_d          = acc_in_q;
    acc_out_d         = acc_out_q;
    lines_in_d        = lines_in_q;
    lines_out_d       = lines_out_q;
    px_cnt_d          = px_cnt_q;
    line_en_d         = line_en_q;
    dy_d              = dy_q;
    frame_lines_in_d  = frame_lines_in_q;
    frame_lines_out_d = frame_lines_out_q;
    cfg_apply         = 1'b0;
    line_end          = 1'b0;
    to_frame_end      = 1'b0;
    acc_in_nxt        = acc_in_q + STEP_ACC;

    case (state_q)
      // Skip whatever is left of a frame that was in flight at reset.
      S_WAIT_LOW: if (!vs_i) state_d = S_IDLE;
      S_IDLE: begin
        if (vs_rise) begin
          cfg_apply   = 1'b1;
          acc_in_d    = '0;
          acc_out_d   = '0;
          lines_in_d  = '0;
          lines_out_d = '0;
          state_d     = S_HBLANK;
        end
      end
      S_HBLANK: begin
        if (vs_fall) begin
          to_frame_end = 1'b1;
        end else if (hs_fall) begin
          // Emit an output line whenever the input position passes the next
          // output position; one output per input caps upscaling at 1:1.
          line_en_d = (acc_in_nxt > acc_out_q);
          dy_d      = acc_out_q[1 +: DY_WIDTH];
          if (line_en_d) begin
            acc_out_d   = acc_out_q + ACC_WIDTH'(scale_step_o);
            lines_out_d = sat_inc16(lines_out_q);
          end
          acc_in_d   = acc_in_nxt;
          lines_in_d = sat_inc16(lines_in_q);
          px_cnt_d   = '0;
          state_d    = S_LINE;
        end
      end
      S_LINE: begin
        if (de_i && (px_cnt_q != PX_SAT)) px_cnt_d = px_cnt_q + 16'd1;
        if (vs_fall) begin
          line_end     = 1'b1;
          to_frame_end = 1'b1;
        end else if (hs_rise) begin
          line_end = 1'b1;
          state_d  = S_HBLANK;
        end
      end
      S_FRAME_END: state_d = S_IDLE;
      default:     state_d = S_WAIT_LOW;
    endcase

    // Latch the report on entry so it is valid while frame_done_o is high.
    if (to_frame_end) begin
      state_d           = S_FRAME_END;
      frame_lines_in_d  = lines_in_q;
      frame_lines_out_d = lines_out_q;
    end

    err_set              = '0;
    err_set[ERR_LEN_IDX] = line_end && (px_cnt_q != line_in_size_o);
    err_set[ERR_OVF_IDX] = line_end && (px_cnt_q > PX_MAX);
    err_set[ERR_CFG_IDX] = cfg_zero_step;
    // A set in the same cycle as a clear wins.
    err_d = (err_q & ~{ERR_NUM{err_clr}}) | err_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_WAIT_LOW;
      vs_q              <= 1'b0;
      hs_q              <= 1'b0;
      acc_in_q          <= '0;
      acc_out_q         <= '0;
      lines_in_q        <= '0;
      lines_out_q       <= '0;
      px_cnt_q          <= '0;
      line_en_q         <= 1'b0;
      dy_q              <= '0;
      frame_lines_in_q  <= '0;
      frame_lines_out_q <= '0;
      err_q             <= '0;
    end else begin
      state_q           <= state_d;
      vs_q              <= vs_i;
      hs_q              <= hs_i;
      acc_in_q          <= acc_in_d;
      acc_out_q         <= acc_out_d;
      lines_in_q        <= lines_in_d;
      lines_out_q       <= lines_out_d;
      px_cnt_q          <= px_cnt_d;
      line_en_q         <= line_en_d;
      dy_q              <= dy_d;
      frame_lines_in_q  <= frame_lines_in_d;
      frame_lines_out_q <= frame_lines_out_d;
      err_q             <= err_d;
    end
  end

  assign line_en_o         = line_en_q;
  assign dy_o              = dy_q;
  assign frame_done_o      = (state_q == S_FRAME_END);
  assign frame_lines_in_o  = frame_lines_in_q;
  assign frame_lines_out_o = frame_lines_out_q;
  assign err_len_o         = err_q[ERR_LEN_IDX];
  assign err_ovf_o         = err_q[ERR_OVF_IDX];
  assign err_cfg_o         = err_q[ERR_CFG_IDX];

endmodule

// File: tb/tb_scaler_v_sched.sv
// Testbench for scaler_v_sched: directed table, corner sequences, random frames
// checked against a line-level reference model.
module tb_scaler_v_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_scale_step, cfg_line_in_size;
  logic        cfg_wr, vs_i, hs_i, de_i, err_clr;
  logic [15:0] scale_step_o, line_in_size_o;
  logic        line_en_o;
  logic [10:0] dy_o;
  logic        frame_done_o;
  logic [15:0] frame_lines_in_o, frame_lines_out_o;
  logic        err_len_o, err_ovf_o, err_cfg_o;

  always #5 clk = ~clk;

  scaler_v_sched dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_scale_step    (cfg_scale_step),
    .cfg_line_in_size  (cfg_line_in_size),
    .cfg_wr            (cfg_wr),
    .vs_i              (vs_i),
    .hs_i              (hs_i),
    .de_i              (de_i),
    .scale_step_o      (scale_step_o),
    .line_in_size_o    (line_in_size_o),
    .line_en_o         (line_en_o),
    .dy_o              (dy_o),
    .frame_done_o      (frame_done_o),
    .frame_lines_in_o  (frame_lines_in_o),
    .frame_lines_out_o (frame_lines_out_o),
    .err_len_o         (err_len_o),
    .err_ovf_o         (err_ovf_o),
    .err_cfg_o         (err_cfg_o),
    .err_clr           (err_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tracks configuration and line/frame counts only.
  logic [15:0] m_step, m_size, m_pend_step, m_pend_size;
  bit          m_pend;
  bit          m_err_len, m_err_ovf, m_err_cfg;
  longint      m_lin, m_lout, m_fin, m_fout;

  // Per-line knobs consumed by do_line.
  bit          mid_wr = 1'b0;
  logic [15:0] mid_step, mid_size;
  bit          clr_at_end = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_step = 16'd4096; m_size = 16'd1024;
    m_pend_step = 16'd4096; m_pend_size = 16'd1024; m_pend = 1'b0;
    m_err_len = 1'b0; m_err_ovf = 1'b0; m_err_cfg = 1'b0;
    m_lin = 0; m_lout = 0; m_fin = 0; m_fout = 0;
  endtask

  task automatic m_cfg_wr(input logic [15:0] st, input logic [15:0] sz);
    m_pend_step = st; m_pend_size = sz; m_pend = 1'b1;
  endtask

  task automatic m_frame_start();
    if (m_pend) begin
      if (m_pend_step == 16'd0) begin
        m_step = 16'd4096;
        m_err_cfg = 1'b1;
      end else begin
        m_step = m_pend_step;
      end
      m_size = m_pend_size;
      m_pend = 1'b0;
    end
    m_lin = 0; m_lout = 0;
  endtask

  // Output line j sits at input position j*step; input line k ends at (k+1)*1.000.
  // Input line k emits the next output line if that output lies before its end.
  task automatic m_decide(output logic en, output logic [10:0] dy);
    longint out_pos;
    out_pos = m_lout * longint'(m_step);
    en = (out_pos < (m_lin + 1) * 4096);
    dy = 11'((out_pos / 2) % 2048);
    if (en) m_lout++;
    m_lin++;
  endtask

  task automatic m_line_end(input int px, input bit clr);
    int pxs;
    pxs = (px > 1025) ? 1025 : px;
    if (clr) begin m_err_len = 1'b0; m_err_ovf = 1'b0; m_err_cfg = 1'b0; end
    if (pxs != int'(m_size)) m_err_len = 1'b1;
    if (pxs > 1024) m_err_ovf = 1'b1;
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, "_err_len"}, err_len_o, m_err_len);
    chk({tag, "_err_ovf"}, err_ovf_o, m_err_ovf);
    chk({tag, "_err_cfg"}, err_cfg_o, m_err_cfg);
  endtask

  task automatic cfg_write(input logic [15:0] st, input logic [15:0] sz);
    cfg_scale_step = st; cfg_line_in_size = sz; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    m_cfg_wr(st, sz);
  endtask

  task automatic frame_start(input bit wr, input logic [15:0] st, input logic [15:0] sz);
    vs_i = 1'b1;
    if (wr) begin
      cfg_scale_step = st; cfg_line_in_size = sz; cfg_wr = 1'b1;
    end
    tick();
    cfg_wr = 1'b0;
    m_frame_start();
    if (wr) m_cfg_wr(st, sz);
    chk("fs_scale_step", scale_step_o, m_step);
    chk("fs_line_size", line_in_size_o, m_size);
    chk("fs_err_cfg", err_cfg_o, m_err_cfg);
    tick();
  endtask

  task automatic do_line(input int px);
    logic        exp_en;
    logic [10:0] exp_dy;
    hs_i = 1'b0;
    tick();
    m_decide(exp_en, exp_dy);
    chk("line_en", line_en_o, exp_en);
    chk("dy", dy_o, exp_dy);
    for (int i = 0; i < px; i++) begin
      de_i = 1'b1;
      cfg_wr = mid_wr && (i == 1);
      if (mid_wr && i == 1) begin
        cfg_scale_step = mid_step; cfg_line_in_size = mid_size;
      end
      tick();
      if (mid_wr && i == 1) m_cfg_wr(mid_step, mid_size);
    end
    cfg_wr = 1'b0; de_i = 1'b0; hs_i = 1'b1; err_clr = clr_at_end;
    tick();
    err_clr = 1'b0;
    m_line_end(px, clr_at_end);
    chk_errs("line_end");
    chk("line_en_held", line_en_o, exp_en);
    chk("active_step_in_frame", scale_step_o, m_step);
    mid_wr = 1'b0; clr_at_end = 1'b0;
    tick();
  endtask

  task automatic frame_end();
    vs_i = 1'b0;
    tick();
    m_fin = m_lin; m_fout = m_lout;
    chk("frame_done_hi", frame_done_o, 1'b1);
    chk("frame_lines_in", frame_lines_in_o, m_fin);
    chk("frame_lines_out", frame_lines_out_o, m_fout);
    tick();
    chk("frame_done_lo", frame_done_o, 1'b0);
    tick();
  endtask

  task automatic err_clear();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err_len = 1'b0; m_err_ovf = 1'b0; m_err_cfg = 1'b0;
    chk_errs("err_clr");
  endtask

  typedef struct {
    logic [15:0] step;
    logic [15:0] size;
    int          lines;
    int          px;
    int          exp_out;
    bit          exp_len;
  } vec_t;

  vec_t        vecs[5];
  bit          seen_done;
  int          nl, px;
  logic [15:0] st, sz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'd4096,  16'd16, 8, 16, 8, 1'b0};  // 1:1
    vecs[1] = '{16'd8192,  16'd16, 8, 16, 4, 1'b0};  // 2:1
    vecs[2] = '{16'd2048,  16'd8,  8, 8,  8, 1'b0};  // upscale saturates at 1:1
    vecs[3] = '{16'd12288, 16'd8,  9, 8,  3, 1'b0};  // 3:1
    vecs[4] = '{16'd6144,  16'd12, 8, 11, 6, 1'b1};  // 1.5:1, short lines

    rst = 1'b1; cfg_scale_step = '0; cfg_line_in_size = '0; cfg_wr = 1'b0;
    vs_i = 1'b0; hs_i = 1'b1; de_i = 1'b0; err_clr = 1'b0;
    m_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_scale_step", scale_step_o, 16'd4096);
    chk("rst_line_size", line_in_size_o, 16'd1024);
    chk("rst_line_en", line_en_o, 1'b0);
    chk("rst_dy", dy_o, 11'd0);
    chk("rst_frame_done", frame_done_o, 1'b0);
    chk("rst_lines_in", frame_lines_in_o, 16'd0);
    chk("rst_lines_out", frame_lines_out_o, 16'd0);
    chk_errs("rst");

    // Table-driven frames with hand-computed frame results
    for (int v = 0; v < 5; v++) begin
      cfg_write(vecs[v].step, vecs[v].size);
      frame_start(1'b0, 16'd0, 16'd0);
      for (int l = 0; l < vecs[v].lines; l++) do_line(vecs[v].px);
      frame_end();
      chk("vec_lines_in", frame_lines_in_o, vecs[v].lines);
      chk("vec_lines_out", frame_lines_out_o, vecs[v].exp_out);
      chk("vec_err_len", err_len_o, vecs[v].exp_len);
      err_clear();
    end

    // Mid-frame cfg_wr only takes effect at the next frame start
    cfg_write(16'd4096, 16'd16);
    frame_start(1'b0, 16'd0, 16'd0);
    for (int l = 0; l < 8; l++) begin
      if (l == 3) begin mid_wr = 1'b1; mid_step = 16'd6144; mid_size = 16'd16; end
      do_line(16);
    end
    chk("midwr_still_old", scale_step_o, 16'd4096);
    frame_end();
    frame_start(1'b0, 16'd0, 16'd0);
    chk("midwr_applied", scale_step_o, 16'd6144);
    for (int l = 0; l < 8; l++) do_line(16);
    frame_end();
    chk("midwr_lines_out", frame_lines_out_o, 16'd6);

    // cfg_wr coincident with frame start: older pending value wins this frame
    cfg_write(16'd8192, 16'd16);
    frame_start(1'b1, 16'd4096, 16'd16);
    chk("same_cycle_old", scale_step_o, 16'd8192);
    for (int l = 0; l < 4; l++) do_line(16);
    frame_end();
    frame_start(1'b0, 16'd0, 16'd0);
    chk("same_cycle_next", scale_step_o, 16'd4096);
    for (int l = 0; l < 2; l++) do_line(16);
    frame_end();

    // Length / overflow errors; clear coinciding with a set keeps the set
    frame_start(1'b0, 16'd0, 16'd0);
    do_line(15);
    chk("short_line_len", err_len_o, 1'b1);
    do_line(1100);
    chk("long_line_ovf", err_ovf_o, 1'b1);
    clr_at_end = 1'b1;
    do_line(15);
    chk("clr_vs_set_len", err_len_o, 1'b1);
    chk("clr_no_set_ovf", err_ovf_o, 1'b0);
    err_clear();
    do_line(16);
    frame_end();

    // Zero step falls back to 1:1 and flags a config error
    cfg_write(16'd0, 16'd16);
    frame_start(1'b0, 16'd0, 16'd0);
    chk("zero_step_sub", scale_step_o, 16'd4096);
    chk("zero_step_err", err_cfg_o, 1'b1);
    for (int l = 0; l < 3; l++) do_line(16);
    frame_end();
    chk("zero_step_out", frame_lines_out_o, 16'd3);
    err_clear();

    // Reset during line 4
    cfg_write(16'd6144, 16'd16);
    frame_start(1'b0, 16'd0, 16'd0);
    for (int l = 0; l < 4; l++) do_line(16);
    hs_i = 1'b0;
    tick();
    de_i = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; de_i = 1'b0;
    m_reset();
    chk("midrst_scale_step", scale_step_o, 16'd4096);
    chk("midrst_line_size", line_in_size_o, 16'd1024);
    chk("midrst_line_en", line_en_o, 1'b0);
    chk("midrst_lines_in", frame_lines_in_o, 16'd0);
    chk("midrst_lines_out", frame_lines_out_o, 16'd0);
    seen_done = 1'b0;
    hs_i = 1'b1;
    repeat (4) begin tick(); seen_done |= frame_done_o; end
    hs_i = 1'b0; de_i = 1'b1;
    repeat (5) begin tick(); seen_done |= frame_done_o; end
    hs_i = 1'b1; de_i = 1'b0;
    repeat (2) begin tick(); seen_done |= frame_done_o; end
    vs_i = 1'b0;
    repeat (8) begin tick(); seen_done |= frame_done_o; end
    chk("midrst_no_done", seen_done, 1'b0);
    cfg_write(16'd4096, 16'd16);
    frame_start(1'b0, 16'd0, 16'd0);
    for (int l = 0; l < 6; l++) do_line(16);
    frame_end();
    chk("post_rst_lines_in", frame_lines_in_o, 16'd6);
    chk("post_rst_lines_out", frame_lines_out_o, 16'd6);

    // Randomized frames against the reference model
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 2) != 0) begin
        st = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1024, 20000));
        sz = 16'($urandom_range(4, 20));
        cfg_write(st, sz);
      end
      frame_start(1'b0, 16'd0, 16'd0);
      nl = $urandom_range(2, 12);
      for (int l = 0; l < nl; l++) begin
        if ($urandom_range(0, 7) == 0) begin
          mid_wr = 1'b1;
          mid_step = 16'($urandom_range(0, 16384));
          mid_size = 16'($urandom_range(4, 20));
        end
        clr_at_end = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 5))
          0:       px = int'(m_size) - 1;
          1:       px = int'(m_size) + 1;
          default: px = int'(m_size);
        endcase
        do_line(px);
      end
      frame_end();
      if ($urandom_range(0, 3) == 0) err_clear();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
